audio_fir_mac: RTL and testbench

Parametrised multi-channel FIR filter engine for the audio subsystem, succeeding the fixed 32-bit single-stream MAC datapath of the audio DSP. It accepts time-interleaved PCM samples tagged with a channel number and keeps a private sample history per channel. Each sample is run through a TAPS-long convolution against a shared, software-loaded coefficient set, with rounding and saturation. It sits between the PCM input interface and the downstream audio buffers, using valid/ready streams on both sides.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_round_sat.sv | 39 +++
 rtl/audio_fir_mac.sv | 186 ++++++++++++++++++
 tb/tb_audio_fir_mac.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types, default widths and helpers for the multi-channel audio FIR engine.
package audio_pkg;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_COEF_W = 18;
    localparam int unsigned DEF_TAPS   = 32;
    localparam int unsigned DEF_SHIFT  = 16;
    localparam int unsigned DEF_ACC_W  = 48;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } fir_state_e;

    // Half an output LSB in accumulator units; zero when there are no fractional bits.
    function automatic longint unsigned round_const(input int unsigned shift);
        return (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
    endfunction

endpackage

// File: rtl/audio_round_sat.sv
// Round-half-up, arithmetic shift and clamp of the accumulator down to the sample width.
module audio_round_sat
    import audio_pkg::*;
#(
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SHIFT  = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_sat
);

    // One guard bit keeps the rounding add from wrapping near full scale.
    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(round_const(SHIFT));
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((64'd1 << (DATA_W - 1)) - 64'd1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shr;
    logic                  w_hi;
    logic                  w_lo;

    assign w_sum = (ACC_W+1)'(i_acc) + RND;
    assign w_shr = w_sum >>> SHIFT;
    assign w_hi  = (w_shr > MAX_V);
    assign w_lo  = (w_shr < MIN_V);
    assign o_sat = w_hi | w_lo;

    always_comb begin
        o_data = w_shr[DATA_W-1:0];
        if (w_hi) begin
            o_data = MAX_V[DATA_W-1:0];
        end else if (w_lo) begin
            o_data = MIN_V[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/audio_fir_mac.sv
// Multi-channel time-interleaved FIR engine: one sample in, TAPS serial MAC cycles, one sample out.
module audio_fir_mac
    import audio_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned TAPS   = DEF_TAPS,
    parameter int unsigned SHIFT  = DEF_SHIFT,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned TAP_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              coef_we,
    input  logic [TAP_W-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              coef_ready,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [DATA_W-1:0] m_data,
    output logic              sat_irq,
    input  logic              irq_clr
);

    localparam int unsigned      CLR_W    = CH_W + TAP_W;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_CH * TAPS - 1);
    localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(NUM_CH);

    if (ACC_W < DATA_W + COEF_W + TAP_W) begin : g_acc_w_chk
        $error("audio_fir_mac: ACC_W narrower than DATA_W+COEF_W+TAP_W");
    end

    fir_state_e               r_state;
    fir_state_e               w_state_nxt;
    logic [CLR_W-1:0]         r_clr_idx;
    logic [TAP_W-1:0]         r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CH_W-1:0]          r_ch;
    logic [TAP_W-1:0]         r_wp [NUM_CH];
    logic signed [DATA_W-1:0] r_hist [NUM_CH][TAPS];
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic [CH_W-1:0]          r_m_ch;
    logic [DATA_W-1:0]        r_m_data;
    logic                     r_sat_irq;

    logic                     w_valid_ch;
    logic                     w_accept;
    logic                     w_mac_last;
    logic                     w_sat_set;
    logic [TAP_W-1:0]         w_tap_idx;
    logic signed [DATA_W-1:0] w_tap;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [DATA_W-1:0] w_rs_data;
    logic                     w_rs_sat;

    // Out-of-range channels still handshake but are silently discarded.
    assign w_valid_ch = ({1'b0, s_ch} < CH_LIM);
    assign w_accept   = enable & s_valid & (r_state == ST_IDLE) & w_valid_ch;
    assign w_mac_last = &r_k;
    assign w_sat_set  = enable & (r_state == ST_MAC) & w_mac_last & w_rs_sat;

    assign w_tap_idx = r_wp[r_ch] - r_k;
    assign w_tap     = r_hist[r_ch][w_tap_idx];
    assign w_prod    = ACC_W'(r_coef[r_k]) * ACC_W'(w_tap);
    assign w_acc_nxt = r_acc + w_prod;

    assign m_ch    = r_m_ch;
    assign m_data  = r_m_data;
    assign sat_irq = r_sat_irq;

    audio_round_sat #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_acc (w_acc_nxt),
        .o_data(w_rs_data),
        .o_sat (w_rs_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        coef_ready  = 1'b0;
        m_valid     = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                if (enable && (r_clr_idx == CLR_LAST)) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                s_ready    = enable;
                coef_ready = enable;
                if (w_accept) w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (enable && w_mac_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (enable && m_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // Datapath control: clear sweep, tap walk, pointer advance and output capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_ch      <= '0;
            r_m_ch    <= '0;
            r_m_data  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wp[c] <= '0;
            end
        end else if (enable) begin
            case (r_state)
                ST_CLEAR: r_clr_idx <= r_clr_idx + CLR_W'(1);
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ch  <= s_ch;
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + TAP_W'(1);
                    if (w_mac_last) begin
                        r_wp[r_ch] <= r_wp[r_ch] + TAP_W'(1);
                        r_m_data   <= w_rs_data;
                        r_m_ch     <= r_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_irq <= 1'b0;
        end else if (w_sat_set) begin
            r_sat_irq <= 1'b1;
        end else if (irq_clr) begin
            r_sat_irq <= 1'b0;
        end
    end

    // History is zeroed by the CLEAR sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (r_state == ST_CLEAR) begin
                r_hist[r_clr_idx[TAP_W +: CH_W]][r_clr_idx[TAP_W-1:0]] <= '0;
            end else if (w_accept) begin
                r_hist[s_ch][r_wp[s_ch]] <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (coef_we && coef_ready) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_audio_fir_mac.sv
// Directed self-checking bench for audio_fir_mac at default parameters.
module tb_audio_fir_mac;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned COEF_W = 18;
    localparam int unsigned TAP_W  = 5;
    localparam int unsigned CH_W   = 1;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              enable     = 1'b1;
    logic              coef_we    = 1'b0;
    logic [TAP_W-1:0]  coef_addr  = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              coef_ready;
    logic              s_valid    = 1'b0;
    logic              s_ready;
    logic [CH_W-1:0]   s_ch       = '0;
    logic [DATA_W-1:0] s_data     = '0;
    logic              m_valid;
    logic              m_ready    = 1'b1;
    logic [CH_W-1:0]   m_ch;
    logic [DATA_W-1:0] m_data;
    logic              sat_irq;
    logic              irq_clr    = 1'b0;

    int checks = 0;
    int errors = 0;
    int lat;
    int n;

    always #5 clk = ~clk;

    audio_fir_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .coef_ready(coef_ready),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_ch      (s_ch),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_ch      (m_ch),
        .m_data    (m_data),
        .sat_irq   (sat_irq),
        .irq_clr   (irq_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_coef(input int k, input logic [COEF_W-1:0] v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = TAP_W'(k);
        coef_wdata = v;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!s_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_reset(input string tag);
        int c;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(c);
        chk(tag, c, 64);
    endtask

    // Handshake one sample, optionally stall enable mid-MAC, and stop at the first m_valid.
    task automatic push(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d,
                        input int pause, output int l);
        int c;
        @(negedge clk);
        wait_ready(c);
        s_valid = 1'b1;
        s_ch    = ch;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        l = 0;
        if (pause > 0) begin
            repeat (3) @(negedge clk);
            l += 3;
            enable = 1'b0;
            repeat (pause) @(negedge clk);
            l += pause;
            enable = 1'b1;
        end
        while (!m_valid && l < 300) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [CH_W-1:0] ch,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
        int l;
        push(ch, d, 0, l);
        chk({tag, "_lat"}, l, 32);
        chk({tag, "_data"}, m_data, exp);
        chk({tag, "_ch"}, m_ch, ch);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_coef_ready", coef_ready, 0);
        chk("rst_sat_irq", sat_irq, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ch", m_ch, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        chk("clear_len_init", n, 64);
        for (int k = 0; k < 32; k++) wr_coef(k, '0);

        // Unity passthrough
        wr_coef(0, 18'h10000);
        run("unity", 1'b0, 24'h100000, 24'h100000);
        chk("unity_s_ready_back", s_ready, 1);

        // Three-sample delay line
        do_reset("clear_len_delay");
        wr_coef(0, 18'h0);
        wr_coef(3, 18'h10000);
        for (int i = 1; i <= 5; i++) begin
            run("delay", 1'b0, 24'(i), (i < 4) ? 24'h0 : 24'(i - 3));
        end

        // Channel isolation with one-sample delay
        do_reset("clear_len_iso");
        wr_coef(3, 18'h0);
        wr_coef(1, 18'h10000);
        run("iso_a", 1'b0, 24'd7, 24'd0);
        run("iso_b", 1'b1, 24'd9, 24'd0);
        run("iso_c", 1'b0, 24'd0, 24'd7);
        run("iso_d", 1'b1, 24'd0, 24'd9);

        // Positive and negative saturation, sticky irq and clear
        do_reset("clear_len_sat");
        wr_coef(0, 18'h10000);
        run("sat_p1", 1'b0, 24'h7FFFFF, 24'h7FFFFF);
        chk("sat_p1_irq", sat_irq, 0);
        run("sat_p2", 1'b0, 24'h7FFFFF, 24'h7FFFFF);
        chk("sat_p2_irq", sat_irq, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("sat_irq_clr", sat_irq, 0);
        run("sat_n1", 1'b0, 24'h800000, 24'hFFFFFF);
        chk("sat_n1_irq", sat_irq, 0);
        run("sat_n2", 1'b0, 24'h800000, 24'h800000);
        chk("sat_n2_irq", sat_irq, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;

        // Rounding at exactly half an LSB
        wr_coef(1, 18'h0);
        wr_coef(0, 18'h08000);
        run("rnd_pos", 1'b1, 24'd3, 24'd2);
        run("rnd_neg", 1'b1, 24'hFFFFFD, 24'hFFFFFF);

        // Backpressure holds OUT and blocks coefficient writes
        m_ready = 1'b0;
        push(1'b0, 24'h100, 0, lat);
        chk("bp_lat", lat, 32);
        chk("bp_data0", m_data, 24'h80);
        for (int i = 0; i < 10; i++) begin
            coef_we    = 1'b1;
            coef_addr  = '0;
            coef_wdata = 18'h10000;
            @(negedge clk);
            chk("bp_valid", m_valid, 1);
            chk("bp_data", m_data, 24'h80);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_coef_ready", coef_ready, 0);
        end
        coef_we = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        run("bp_after", 1'b0, 24'h100, 24'h80);

        // Enable pause in MAC stretches latency without changing the result
        push(1'b0, 24'h40, 5, lat);
        chk("pause_lat", lat, 37);
        chk("pause_data", m_data, 24'h20);
        @(negedge clk);

        // Reset at k=10 aborts the operation and re-clears history
        wr_coef(5, 18'h10000);
        @(negedge clk);
        wait_ready(n);
        s_valid = 1'b1;
        s_ch    = 1'b0;
        s_data  = 24'h1000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmac_m_valid", m_valid, 0);
        chk("rstmac_s_ready", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        chk("rstmac_clear_len", n, 64);
        chk("rstmac_no_out", m_valid, 0);
        run("rstmac_impulse", 1'b0, 24'h200, 24'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
